// File: rtl/ccg_response_misr_pkg.sv
// Shared BIST definitions: response/signature widths, MISR defaults
// and the run-state encoding used by the CCG test blocks.
package ccg_bist_pkg;

  localparam int RESP_W = 18;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 16;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_t;

endpackage

// File: rtl/ccg_response_misr_if.sv
// Response handshake bundle between the circuit under test
// and the signature compactor.
interface ccg_response_misr_if
  import ccg_bist_pkg::*;
#(
  parameter int W = RESP_W
);

  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/ccg_response_misr_core.sv
// Multiple-input signature register: seeded on load, folds one
// zero-extended response vector per enabled cycle.
module ccg_misr_core #(
  parameter int                 RESP_W = 18,
  parameter int                 SIG_W  = 32,
  parameter logic [SIG_W-1:0]   POLY   = 32'h04C1_1DB7,
  parameter logic [SIG_W-1:0]   SEED   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] fb;
  logic [SIG_W-1:0] sig_nxt;

  assign fb      = sig[SIG_W-1] ? POLY : '0;
  assign sig_nxt = {sig[SIG_W-2:0], 1'b0}
                 ^ fb
                 ^ SIG_W'(data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/ccg_response_misr.sv
// Response compactor: run control, vector counting and golden
// signature comparison around the MISR core.
module ccg_response_misr
  import ccg_bist_pkg::*;
#(
  parameter int                 RESP_W = ccg_bist_pkg::RESP_W,
  parameter int                 SIG_W  = ccg_bist_pkg::SIG_W,
  parameter int                 CNT_W  = ccg_bist_pkg::CNT_W,
  parameter logic [SIG_W-1:0]   POLY   = ccg_bist_pkg::POLY,
  parameter logic [SIG_W-1:0]   SEED   = ccg_bist_pkg::SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  input  logic [SIG_W-1:0]     golden,
  ccg_response_misr_if.slave   resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [CNT_W-1:0]     vec_count
);

  misr_state_t      state_q;
  misr_state_t      state_d;
  logic [CNT_W-1:0] num_q;
  logic [SIG_W-1:0] gold_q;
  logic             load;
  logic             acc;
  logic             last;

  assign last = (vec_count == num_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc = resp.valid;
        if (acc && last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      gold_q    <= '0;
      vec_count <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        num_q     <= num_vec;
        gold_q    <= golden;
        vec_count <= '0;
      end else if (acc) begin
        vec_count <= vec_count + CNT_W'(1);
      end
    end
  end

  assign resp.ready = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = done && (signature == gold_q);

  ccg_misr_core #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (acc),
    .data (resp.data),
    .sig  (signature)
  );

endmodule
